// File: rtl/pw_bit_pkg.sv
// Shared definitions for the pulse-width bit cells (pw_bit_cell, pw_bit_rx_cell).
//
// Contents:
//   PW_BIT_COUNTER_WIDTH  default width of pulse/idle counters and cfg registers
//   PW_BIT_DATA_WIDTH     default bits per byte / output beat
//   pw_bit_rx_state_t     receiver state encoding {IDLE, HIGH, LOW, STUCK}
package pw_bit_pkg;

  localparam int PW_BIT_COUNTER_WIDTH = 32;
  localparam int PW_BIT_DATA_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } pw_bit_rx_state_t;

endpackage

// File: rtl/pw_bit_rx_cell_if.sv
// Stream bundle of pw_bit_rx_cell: decoded-data AXI4-Stream output plus the
// threshold and timeout configuration AXI4-Stream inputs.
//
// Modports:
//   master  receiver side: drives data_m_axis_*, accepts cfg_*_s_axis_*
//   slave   environment side: mirror of master
interface pw_bit_rx_cell_if
  import pw_bit_pkg::*;
#(
  parameter int DATA_AXIS_DATA_WIDTH = PW_BIT_DATA_WIDTH,
  parameter int CFG_AXIS_DATA_WIDTH  = PW_BIT_COUNTER_WIDTH
);

  logic [DATA_AXIS_DATA_WIDTH-1:0] data_m_axis_tdata;
  logic                            data_m_axis_tlast;
  logic                            data_m_axis_tvalid;
  logic                            data_m_axis_tready;

  logic [CFG_AXIS_DATA_WIDTH-1:0]  cfg_threshold_s_axis_tdata;
  logic                            cfg_threshold_s_axis_tvalid;
  logic                            cfg_threshold_s_axis_tready;

  logic [CFG_AXIS_DATA_WIDTH-1:0]  cfg_timeout_s_axis_tdata;
  logic                            cfg_timeout_s_axis_tvalid;
  logic                            cfg_timeout_s_axis_tready;

  modport master (
    output data_m_axis_tdata, data_m_axis_tlast, data_m_axis_tvalid,
    input  data_m_axis_tready,
    input  cfg_threshold_s_axis_tdata, cfg_threshold_s_axis_tvalid,
    output cfg_threshold_s_axis_tready,
    input  cfg_timeout_s_axis_tdata, cfg_timeout_s_axis_tvalid,
    output cfg_timeout_s_axis_tready
  );

  modport slave (
    input  data_m_axis_tdata, data_m_axis_tlast, data_m_axis_tvalid,
    output data_m_axis_tready,
    output cfg_threshold_s_axis_tdata, cfg_threshold_s_axis_tvalid,
    input  cfg_threshold_s_axis_tready,
    output cfg_timeout_s_axis_tdata, cfg_timeout_s_axis_tvalid,
    input  cfg_timeout_s_axis_tready
  );

endinterface

// File: rtl/pw_bit_rx_edge.sv
// Line conditioning for pw_bit_rx_cell: optional 2-flop synchroniser followed
// by a rise/fall detector on the conditioned line.
//
// Build option: PW_BIT_RX_SYNC_EN defined -> rxd passes through two flops
// (reset to 0) before use; undefined -> rxd is assumed synchronous to aclk.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   rxd            raw line input
//   rxd_s          conditioned line
//   rise, fall     single-cycle edge flags, valid in the cycle rxd_s changes
module pw_bit_rx_edge (
  input  logic aclk,
  input  logic aresetn,
  input  logic rxd,
  output logic rxd_s,
  output logic rise,
  output logic fall
);

  logic rxd_d;

`ifdef PW_BIT_RX_SYNC_EN
  logic rxd_p0;
  logic rxd_p1;

  // synchroniser stages
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rxd_p0 <= 1'b0;
      rxd_p1 <= 1'b0;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rxd_s = rxd_p1;
`else
  assign rxd_s = rxd;
`endif

  // edge-detect delay stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rxd_d <= 1'b0;
    else          rxd_d <= rxd_s;
  end

  assign rise = rxd_s & ~rxd_d;
  assign fall = ~rxd_s & rxd_d;

endmodule

// File: rtl/pw_bit_rx_cell.sv
// Pulse-width bit receiver. Measures the high time of each pulse on rxd:
// high time >= threshold decodes as 1, shorter as 0. Bits are packed MSB
// first into bytes; a low period reaching the timeout closes the frame and
// the frame's last byte leaves with tlast. A high period reaching the timeout
// is treated as a stuck line and discards the frame.
//
// The newest complete byte is always held back as "pending" so that the
// frame close can tag it with tlast; it is pushed when the next byte
// completes (tlast=0) or when the frame closes (tlast=1).
//
// Build option: PW_BIT_RX_SYNC_EN (see pw_bit_rx_edge).
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   rxd            pulse-width encoded line, idle low
//   bus            data_m_axis_* output stream, cfg_threshold/timeout inputs
//   frame_err      1-cycle pulse: partial byte or stuck line discarded
//   overrun        1-cycle pulse: byte dropped, output register full
module pw_bit_rx_cell
  import pw_bit_pkg::*;
#(
  parameter int COUNTER_WIDTH        = PW_BIT_COUNTER_WIDTH,
  parameter int DATA_AXIS_DATA_WIDTH = PW_BIT_DATA_WIDTH,
  parameter int CFG_AXIS_DATA_WIDTH  = COUNTER_WIDTH,
  parameter int DEFAULT_THRESHOLD    = 50,
  parameter int DEFAULT_TIMEOUT      = 150
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rxd,
  pw_bit_rx_cell_if.master      bus,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW  = COUNTER_WIDTH;
  localparam int DW  = DATA_AXIS_DATA_WIDTH;
  localparam int BCW = $clog2(DW + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_HIGH  = HIGH;
  localparam logic [1:0] ST_LOW   = LOW;
  localparam logic [1:0] ST_STUCK = STUCK;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic          rxd_s;
  logic          rise;
  logic          fall;

  logic [1:0]    state;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;
  logic [CW-1:0] threshold;
  logic [CW-1:0] timeout_val;
  logic [CW-1:0] timeout_eff;
  logic [DW-1:0] shreg;
  logic [BCW-1:0] bit_cnt;
  logic [DW-1:0] pend_data;
  logic          pend_vld;
  logic          rst_done;

  logic          bit_val;
  logic [DW-1:0] shifted;
  logic          byte_done;
  logic          lo_timeout;
  logic          hi_timeout;
  logic          push_req;
  logic [DW-1:0] push_data;
  logic          push_last;
  logic          err_evt;
  logic          cfg_rdy;

  pw_bit_rx_edge u_edge (
    .aclk    (aclk),
    .aresetn (aresetn),
    .rxd     (rxd),
    .rxd_s   (rxd_s),
    .rise    (rise),
    .fall    (fall)
  );

  // A timeout of 0 would otherwise fire in the same cycle a state is entered.
  assign timeout_eff = (timeout_val == '0) ? CW'(1) : timeout_val;
  assign bit_val     = (hi_cnt >= threshold);
  assign shifted     = {shreg[DW-2:0], bit_val};
  assign byte_done   = (bit_cnt == BCW'(DW - 1));
  assign lo_timeout  = (state == ST_LOW)  && !rise && (lo_cnt >= timeout_eff);
  assign hi_timeout  = (state == ST_HIGH) && !fall && (hi_cnt >= timeout_eff);

  // cfg is only taken between frames; rst_done keeps tready low during reset
  assign cfg_rdy = rst_done && (state == ST_IDLE);
  assign bus.cfg_threshold_s_axis_tready = cfg_rdy;
  assign bus.cfg_timeout_s_axis_tready   = cfg_rdy;

  always_comb begin
    push_req  = 1'b0;
    push_data = pend_data;
    push_last = 1'b0;
    err_evt   = 1'b0;
    if ((state == ST_HIGH) && fall && byte_done && pend_vld) begin
      push_req = 1'b1;
    end
    if (lo_timeout) begin
      push_req  = pend_vld;
      push_last = 1'b1;
      err_evt   = (bit_cnt != '0);
    end
    if (hi_timeout) begin
      err_evt = 1'b1;
    end
  end

  // decode FSM stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      pend_data <= '0;
      pend_vld  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state  <= ST_HIGH;
            hi_cnt <= CW'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state  <= ST_LOW;
            lo_cnt <= CW'(1);
            if (byte_done) begin
              pend_data <= shifted;
              pend_vld  <= 1'b1;
              shreg     <= '0;
              bit_cnt   <= '0;
            end else begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end else if (hi_timeout) begin
            state    <= ST_STUCK;
            shreg    <= '0;
            bit_cnt  <= '0;
            pend_vld <= 1'b0;
          end else begin
            hi_cnt <= sat_inc(hi_cnt);
          end
        end
        ST_LOW: begin
          if (rise) begin
            state  <= ST_HIGH;
            hi_cnt <= CW'(1);
          end else if (lo_timeout) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            pend_vld <= 1'b0;
          end else begin
            lo_cnt <= sat_inc(lo_cnt);
          end
        end
        default: begin
          if (!rxd_s) state <= ST_IDLE;
        end
      endcase
    end
  end

  // output register stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.data_m_axis_tvalid <= 1'b0;
      bus.data_m_axis_tdata  <= '0;
      bus.data_m_axis_tlast  <= 1'b0;
      overrun                <= 1'b0;
      frame_err              <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= err_evt;
      if (push_req) begin
        // the register frees in a handshake cycle, so that push still lands
        if (!bus.data_m_axis_tvalid || bus.data_m_axis_tready) begin
          bus.data_m_axis_tvalid <= 1'b1;
          bus.data_m_axis_tdata  <= push_data;
          bus.data_m_axis_tlast  <= push_last;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.data_m_axis_tvalid && bus.data_m_axis_tready) begin
        bus.data_m_axis_tvalid <= 1'b0;
      end
    end
  end

  // configuration stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done    <= 1'b0;
      threshold   <= CW'(DEFAULT_THRESHOLD);
      timeout_val <= CW'(DEFAULT_TIMEOUT);
    end else begin
      rst_done <= 1'b1;
      if (bus.cfg_threshold_s_axis_tvalid && cfg_rdy)
        threshold <= bus.cfg_threshold_s_axis_tdata[CW-1:0];
      if (bus.cfg_timeout_s_axis_tvalid && cfg_rdy)
        timeout_val <= bus.cfg_timeout_s_axis_tdata[CW-1:0];
    end
  end

endmodule

// File: tb/tb_pw_bit_rx_cell.sv
// Bench for pw_bit_rx_cell: directed and randomized frames, decoded by a
// frame-level reference model (pulse widths -> bits -> bytes) and compared
// with the beats, frame_err and overrun pulses collected by a monitor.
module tb_pw_bit_rx_cell;

  logic aclk = 1'b0;
  logic aresetn;
  logic rxd;
  logic frame_err;
  logic overrun;

  pw_bit_rx_cell_if #(.DATA_AXIS_DATA_WIDTH(8), .CFG_AXIS_DATA_WIDTH(32)) bus ();

  pw_bit_rx_cell #(
    .COUNTER_WIDTH(32), .DATA_AXIS_DATA_WIDTH(8), .CFG_AXIS_DATA_WIDTH(32),
    .DEFAULT_THRESHOLD(50), .DEFAULT_TIMEOUT(150)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .rxd       (rxd),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // monitor state (written only by the monitor)
  logic [8:0] got_beats[$];
  int got_ferr = 0;
  int got_ovr = 0;
  int hold_viol = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.data_m_axis_tvalid || bus.data_m_axis_tdata !== prev_data ||
                         bus.data_m_axis_tlast !== prev_last))
        hold_viol++;
      if (bus.data_m_axis_tvalid && bus.data_m_axis_tready)
        got_beats.push_back({bus.data_m_axis_tlast, bus.data_m_axis_tdata});
      if (frame_err) got_ferr++;
      if (overrun) got_ovr++;
      prev_stall = bus.data_m_axis_tvalid && !bus.data_m_axis_tready;
      prev_data  = bus.data_m_axis_tdata;
      prev_last  = bus.data_m_axis_tlast;
    end
  end

  // reference model state
  int cur_thr = 50;
  int fr_hi[$];
  int fr_lo[$];
  logic [8:0] exp_beats[$];
  int exp_ferr = 0;
  int exp_ovr = 0;
  int b0 = 0, f0 = 0, o0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    b0 = got_beats.size();
    f0 = got_ferr;
    o0 = got_ovr;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_nbeats"}, got_beats.size() - b0, exp_beats.size());
    for (int i = 0; i < exp_beats.size(); i++)
      if (b0 + i < got_beats.size())
        check({tag, "_beat"}, {23'd0, got_beats[b0 + i]}, {23'd0, exp_beats[i]});
    check({tag, "_frame_err"}, got_ferr - f0, exp_ferr);
    check({tag, "_overrun"}, got_ovr - o0, exp_ovr);
    check({tag, "_hold"}, hold_viol, 0);
    exp_beats.delete();
    exp_ferr = 0;
    exp_ovr = 0;
    snapshot();
  endtask

  // Frame decode from first principles: each high time >= threshold is a 1,
  // bits group MSB-first into bytes, the last whole byte carries tlast,
  // leftover bits are an error.
  task automatic model_frame();
    int n = fr_hi.size();
    int nbytes = n / 8;
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] v = 8'd0;
      for (int k = 0; k < 8; k++)
        v = {v[6:0], (fr_hi[b * 8 + k] >= cur_thr)};
      exp_beats.push_back({(b == nbytes - 1), v});
    end
    if (n % 8 != 0) exp_ferr++;
  endtask

  task automatic pulse(input int hi, input int lo);
    rxd = 1'b1;
    repeat (hi) @(posedge aclk);
    #1;
    rxd = 1'b0;
    repeat (lo) @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] v, input int hi1, input int lo1,
                          input int hi0, input int lo0);
    for (int k = 7; k >= 0; k--) begin
      fr_hi.push_back(v[k] ? hi1 : hi0);
      fr_lo.push_back(v[k] ? lo1 : lo0);
    end
  endtask

  task automatic play(input int from, input int upto);
    for (int i = from; i < upto; i++) pulse(fr_hi[i], fr_lo[i]);
  endtask

  task automatic finish_frame(input bit do_model);
    idle(300);
    if (do_model) model_frame();
    fr_hi.delete();
    fr_lo.delete();
  endtask

  task automatic play_frame();
    play(0, fr_hi.size());
    finish_frame(1'b1);
  endtask

  task automatic cfg_write(input bit is_to, input logic [31:0] v);
    bit ok = 1'b0;
    if (is_to) begin
      bus.cfg_timeout_s_axis_tdata = v;  bus.cfg_timeout_s_axis_tvalid = 1'b1;
    end else begin
      bus.cfg_threshold_s_axis_tdata = v; bus.cfg_threshold_s_axis_tvalid = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      if (is_to ? bus.cfg_timeout_s_axis_tready : bus.cfg_threshold_s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      @(posedge aclk);
      #1;
    end
    if (ok) begin
      @(posedge aclk);
      #1;
    end
    bus.cfg_timeout_s_axis_tvalid = 1'b0;
    bus.cfg_threshold_s_axis_tvalid = 1'b0;
    check("cfg_accept", ok, 1);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    rxd = 1'b0;
    bus.data_m_axis_tready = 1'b1;
    bus.cfg_threshold_s_axis_tdata = '0;
    bus.cfg_threshold_s_axis_tvalid = 1'b0;
    bus.cfg_timeout_s_axis_tdata = '0;
    bus.cfg_timeout_s_axis_tvalid = 1'b0;
    #1;
    check("rst_tvalid", bus.data_m_axis_tvalid, 0);
    check("rst_tdata", bus.data_m_axis_tdata, 0);
    check("rst_tlast", bus.data_m_axis_tlast, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_thr_tready", bus.cfg_threshold_s_axis_tready, 0);
    check("rst_to_tready", bus.cfg_timeout_s_axis_tready, 0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_thr_tready", bus.cfg_threshold_s_axis_tready, 1);
    check("post_rst_to_tready", bus.cfg_timeout_s_axis_tready, 1);
    cfg_write(1'b0, 32'd50);
    cfg_write(1'b1, 32'd150);
    snapshot();

    // single byte
    add_byte(8'hCC, 75, 25, 25, 75);
    play_frame();
    check_results("single");

    // two-byte frame
    add_byte(8'hA5, 75, 25, 25, 75);
    add_byte(8'h3C, 75, 25, 25, 75);
    play_frame();
    check_results("two_byte");

    // threshold boundary: width == threshold is 1, one less is 0
    add_byte(8'hAA, 50, 50, 49, 51);
    play_frame();
    check_results("thr_edge");

    // partial byte
    for (int i = 0; i < 5; i++) begin
      fr_hi.push_back(75);
      fr_lo.push_back(25);
    end
    play_frame();
    check_results("partial");

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      int nbits = $urandom_range(20, 1);
      for (int i = 0; i < nbits; i++) begin
        fr_hi.push_back($urandom_range(1, 0) ? $urandom_range(100, 50) : $urandom_range(49, 2));
        fr_lo.push_back($urandom_range(100, 3));
      end
      play_frame();
      check_results("random");
    end

    // backpressure: three two-byte frames into a stalled output
    bus.data_m_axis_tready = 1'b0;
    add_byte(8'h11, 75, 25, 25, 75); add_byte(8'h22, 75, 25, 25, 75);
    play(0, 16); finish_frame(1'b0);
    add_byte(8'h33, 75, 25, 25, 75); add_byte(8'h44, 75, 25, 25, 75);
    play(0, 16); finish_frame(1'b0);
    add_byte(8'h55, 75, 25, 25, 75); add_byte(8'h66, 75, 25, 25, 75);
    play(0, 16); finish_frame(1'b0);
    check("bp_tvalid", bus.data_m_axis_tvalid, 1);
    check("bp_tdata", bus.data_m_axis_tdata, 8'h11);
    check("bp_tlast", bus.data_m_axis_tlast, 0);
    bus.data_m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("bp_drained", bus.data_m_axis_tvalid, 0);
    exp_beats.push_back({1'b0, 8'h11});
    exp_ovr = 5;
    check_results("backpressure");

    // threshold write mid-frame stalls until the frame closes
    for (int i = 0; i < 8; i++) begin
      fr_hi.push_back(60);
      fr_lo.push_back(40);
    end
    play(0, 4);
    bus.cfg_threshold_s_axis_tdata = 32'd80;
    bus.cfg_threshold_s_axis_tvalid = 1'b1;
    #1;
    check("mid_tready_a", bus.cfg_threshold_s_axis_tready, 0);
    play(4, 8);
    check("mid_tready_b", bus.cfg_threshold_s_axis_tready, 0);
    finish_frame(1'b1);
    check("mid_tready_idle", bus.cfg_threshold_s_axis_tready, 1);
    bus.cfg_threshold_s_axis_tvalid = 1'b0;
    check_results("mid_old_thr");
    cur_thr = 80;
    add_byte(8'h00, 75, 25, 75, 25);
    play_frame();
    check_results("mid_new_thr");

    // threshold 0: every pulse is a 1
    cfg_write(1'b0, 32'd0);
    cur_thr = 0;
    add_byte(8'h00, 75, 25, 25, 75);
    play_frame();
    check_results("thr_zero");
    cfg_write(1'b0, 32'd50);
    cur_thr = 50;

    // stuck line after a complete byte: everything discarded
    add_byte(8'hF0, 75, 25, 25, 75);
    play(0, 8);
    rxd = 1'b1;
    repeat (200) @(posedge aclk);
    #1;
    finish_frame(1'b0);
    exp_ferr = 1;
    check_results("stuck");

    // reset mid-frame with a held beat and a non-default threshold
    cfg_write(1'b0, 32'd30);
    bus.data_m_axis_tready = 1'b0;
    add_byte(8'h81, 75, 25, 25, 75);
    play(0, 8); finish_frame(1'b0);
    check("rst_pre_tvalid", bus.data_m_axis_tvalid, 1);
    add_byte(8'hF0, 75, 25, 25, 75);
    play(0, 4);
    fr_hi.delete(); fr_lo.delete();
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", bus.data_m_axis_tvalid, 0);
    check("midrst_tdata", bus.data_m_axis_tdata, 0);
    check("midrst_tlast", bus.data_m_axis_tlast, 0);
    check("midrst_thr_tready", bus.cfg_threshold_s_axis_tready, 0);
    repeat (3) @(posedge aclk);
    #1;
    bus.data_m_axis_tready = 1'b1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("midrst_tready_after", bus.cfg_timeout_s_axis_tready, 1);
    check_results("midrst_none");
    cur_thr = 50;
    add_byte(8'h5A, 75, 25, 40, 60);
    play_frame();
    check_results("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pw_bit_rx_cell.md
# pw_bit_rx_cell

Pulse-width bit receiver: the downstream counterpart of `pw_bit_cell`. It measures the high time of each pulse on `rxd` and classifies it against a programmable threshold: long pulse = 1, short pulse = 0. Bits are packed MSB-first into bytes. A programmable idle (low) timeout closes a frame, and the frame's last byte is emitted with `tlast` on an AXI4-Stream master.

## Interface
Parameters:
- `COUNTER_WIDTH`, 32, width of the pulse/idle counters and of the threshold/timeout registers.
- `DATA_AXIS_DATA_WIDTH`, 8, bits per output beat; also the number of bits per byte.
- `CFG_AXIS_DATA_WIDTH`, `COUNTER_WIDTH`, cfg stream width; must be >= `COUNTER_WIDTH`; only the low `COUNTER_WIDTH` bits are used.
- `DEFAULT_THRESHOLD`, 50, threshold value after reset.
- `DEFAULT_TIMEOUT`, 150, idle timeout value after reset.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `rxd` in 1: pulse-width encoded line, idle low.
- `data_m_axis_tdata` out `DATA_AXIS_DATA_WIDTH`: decoded byte.
- `data_m_axis_tlast` out 1: last byte of the frame.
- `data_m_axis_tvalid` out 1; `data_m_axis_tready` in 1.
- `cfg_threshold_s_axis_tdata` in `CFG_AXIS_DATA_WIDTH`; `cfg_threshold_s_axis_tvalid` in 1; `cfg_threshold_s_axis_tready` out 1.
- `cfg_timeout_s_axis_tdata` in `CFG_AXIS_DATA_WIDTH`; `cfg_timeout_s_axis_tvalid` in 1; `cfg_timeout_s_axis_tready` out 1.
- `frame_err` out 1: one-cycle pulse when a partial byte or a stuck-high line is discarded.
- `overrun` out 1: one-cycle pulse when a byte is dropped because the output register is full.

## Operation
- **Edge detection.** `rxd_s` is the (optionally synchronised) `rxd`. Rise and fall are detected from `rxd_s` against its one-cycle-delayed copy.
- **State machine** with four states:
  - `IDLE`: waits for a rise, then goes to `HIGH` with `hi_cnt` = 1.
  - `HIGH`: increments `hi_cnt`. On a fall:
    - bit = (`hi_cnt` >= threshold);
    - shift the bit into `shreg` (MSB first) and increment `bit_cnt`;
    - go to `LOW` with `lo_cnt` = 1.
  - `HIGH`, stuck line: if `hi_cnt` >= timeout before a fall, discard `shreg`, `bit_cnt` and the pending byte, pulse `frame_err`, and go to `STUCK`.
  - `LOW`: a rise returns to `HIGH` (`hi_cnt` = 1). If `lo_cnt` >= timeout, close the frame and go to `IDLE`.
  - `STUCK`: waits for `rxd_s` = 0, then goes to `IDLE`.
- **Counters** saturate at all-ones and never wrap. Comparisons are unsigned. A threshold of 0 decodes every pulse as 1; a timeout of 0 behaves as 1.
- **Byte completion.** When `bit_cnt` reaches `DATA_AXIS_DATA_WIDTH`:
  - if a pending byte exists, push it to the output register with `tlast` = 0;
  - the new byte becomes the pending byte;
  - `bit_cnt` returns to 0.
- **Frame close (timeout in `LOW`):**
  - a pending byte is pushed with `tlast` = 1;
  - a non-zero `bit_cnt` discards the partial bits and pulses `frame_err`;
  - a frame with no complete byte and no partial bits emits nothing.
- **Output register** is one entry deep. A push while `tvalid` = 1 and `tready` = 0 drops the new byte and pulses `overrun`. A push in the same cycle as a handshake is accepted, because the register frees in that cycle.
- **Config streams.** Each `tready` is 1 only while the state is `IDLE`. An accepted value takes effect from the next cycle. Mid-frame writes stall until the frame closes.
- **Reset.** Async assertion clears everything immediately:
  - state = `IDLE`; all counters 0; no pending byte;
  - `tvalid`, `tdata`, `tlast` = 0;
  - `frame_err` = `overrun` = 0;
  - both cfg `tready` = 0 while reset is asserted, 1 from the first cycle after deassertion;
  - threshold/timeout = `DEFAULT_*`.
- **Reset mid-frame** loses the partial frame and emits no beat.

## Timing
- With the synchroniser, `rxd` to `rxd_s` is 2 cycles; without it, 0 cycles.
- Edge detection adds 1 cycle.
- `tvalid` rises the cycle after the push event (a fall completing the next byte, or the timeout compare).
- `frame_err` and `overrun` assert in the cycle after their cause.
- The output holds `tdata`/`tlast` stable while `tvalid` = 1 and `tready` = 0 (AXIS rule).

## Configuration
- `PW_BIT_RX_SYNC_EN` defined: `rxd` passes through a 2-flop synchroniser, which resets to 0. Use for asynchronous line inputs.
- Undefined: `rxd` is used directly. The line must already be synchronous to `aclk`, and all latencies shrink by 2 cycles.

## Structure
- Package `pw_bit_pkg` holds:
  - `typedef enum` `pw_bit_rx_state_t` {`IDLE`, `HIGH`, `LOW`, `STUCK`};
  - shared defaults for `COUNTER_WIDTH`/`DATA_AXIS_DATA_WIDTH`, also used by `pw_bit_cell`.
- One sub-module, `pw_bit_rx_edge`: the optional synchroniser plus rise/fall detector. Outputs: `rxd_s`, `rise`, `fall`.

## Test plan
All scenarios use threshold 50, timeout 150 and transmitter timing period 100 / hi 75 / lo 25, with sync enabled, unless stated otherwise.
- **Single byte:** byte 0xCC, then idle → one beat: `tdata` 0xCC, `tlast` 1, about 150 cycles after the last fall; `frame_err` stays 0.
- **Two-byte frame:** bytes 0xA5, 0x3C back-to-back → beat A5/`tlast` 0, then beat 3C/`tlast` 1.
- **Backpressure / overrun:** `tready` = 0, three two-byte frames → first beat held stable; `overrun` pulses for each later push; releasing `tready` delivers only the first beat.
- **Partial byte:** 5 pulses, then idle → `frame_err` pulses once; no beat.
- **Mid-frame config write / stuck line:**
  - threshold 80 written mid-frame → `tready` stays low until `IDLE`; the next frame of 75-cycle pulses decodes as 0x00.
  - `rxd` held high for 200 cycles → `frame_err` pulses; no beat.
- **Reset mid-frame:** `aresetn` pulsed low after 4 bits → all outputs 0 immediately; a following 0x5A frame decodes correctly.
